// File: rtl/calc_operand_sequencer.sv
// ---------------------------------------------------------------------------
// calc_operand_sequencer
//
// Purpose
//   Front-end sequencer for the calculator ALU. It accumulates decimal keypad
//   digits into two 8-bit operands (A, B), latches the operator, and on '='
//   raises exactly one ALU enable for EXEC_CYCLES cycles. The ALU result is
//   captured on the last EXEC cycle and presented to the display stage as a
//   zero-extended 16-bit value with a one-cycle result_valid pulse, or the
//   sequencer parks in ERR if the ALU flags an error.
//
// Parameters
//   MAX_DIGITS   decimal digits accepted per operand; extra digits ignored
//   EXEC_CYCLES  cycles the ALU enable is held before capture (>= 1)
//
// Build option
//   CALC_CHAIN_EN  when defined, an operator pressed in DONE chains the last
//                  result into A (or goes to ERR if the result exceeds 255).
//                  When undefined, operators in DONE are ignored.
//
// Ports
//   clk           in   1   system clock, rising edge
//   rst_n         in   1   synchronous active-low reset
//   key_valid     in   1   one-cycle key strobe
//   key_type      in   2   00 digit, 01 operator, 10 equals, 11 clear
//   key_val       in   4   digit 0-9, or operator 0 add/1 sub/2 mul/3 div
//   key_ready     out  1   low while in EXEC (only clear is honoured there)
//   A, B          out  8   registered operands to the ALU
//   enable_add/sub/mul/div out 1  one-hot ALU enables, high only in EXEC
//   result_add    in   9   ALU results
//   result_sub    in   8
//   result_mul    in   16
//   result_div    in   8
//   alu_error     in   1   ALU error (sub borrow / divide by zero)
//   result        out  16  captured result
//   result_valid  out  1   one-cycle pulse when result is updated
//   error         out  1   high while in ERR
//   state_dbg     out  3   current state encoding
// ---------------------------------------------------------------------------
module calc_operand_sequencer #(
    parameter int MAX_DIGITS  = 3,
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [1:0]  key_type,
    input  logic [3:0]  key_val,
    output logic        key_ready,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic        enable_add,
    output logic        enable_sub,
    output logic        enable_mul,
    output logic        enable_div,
    input  logic [8:0]  result_add,
    input  logic [7:0]  result_sub,
    input  logic [15:0] result_mul,
    input  logic [7:0]  result_div,
    input  logic        alu_error,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        error,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_EXEC    = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    localparam logic [1:0] KEY_DIGIT = 2'b00;
    localparam logic [1:0] KEY_OP    = 2'b01;
    localparam logic [1:0] KEY_EQ    = 2'b10;
    localparam logic [1:0] KEY_CLR   = 2'b11;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
    localparam int EXEC_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [EXEC_W-1:0] EXEC_LAST = EXEC_W'(EXEC_CYCLES - 1);
    localparam logic [EXEC_W-1:0] EXEC_ONE  = EXEC_W'(1);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t              state_reg,        state_next;
    logic [7:0]          a_reg,            a_next;
    logic [7:0]          b_reg,            b_next;
    logic [CNT_W-1:0]    a_cnt_reg,        a_cnt_next;
    logic [CNT_W-1:0]    b_cnt_reg,        b_cnt_next;
    logic [1:0]          op_reg,           op_next;
    logic [EXEC_W-1:0]   exec_cnt_reg,     exec_cnt_next;
    logic [15:0]         result_reg,       result_next;
    logic                result_valid_reg, result_valid_next;

    // -----------------------------------------------------------------------
    // Helpers shared by the next-state logic
    // -----------------------------------------------------------------------
    logic [7:0]       acc_sel;
    logic [CNT_W-1:0] cnt_sel;
    logic [11:0]      acc_wide;
    logic             digit_ok;
    logic             digit_room;
    logic             op_ok;
    logic             exec_last;
    logic [15:0]      capture_val;

    // Digits go to B only while entering B; everywhere else the target is A.
    assign acc_sel    = (state_reg == ST_ENTER_B) ? b_reg : a_reg;
    assign cnt_sel    = (state_reg == ST_ENTER_B) ? b_cnt_reg : a_cnt_reg;
    // 12 bits holds 255*10+9, so overflow past 255 is detectable exactly.
    assign acc_wide   = ({4'd0, acc_sel} * 12'd10) + {8'd0, key_val};
    assign digit_ok   = (key_val <= 4'd9);
    assign digit_room = (cnt_sel < CNT_MAX);
    assign op_ok      = (key_val[3:2] == 2'b00);
    assign exec_last  = (exec_cnt_reg == EXEC_LAST);

    always_comb begin
        capture_val = 16'd0;
        case (op_reg)
            OP_ADD:  capture_val = {7'd0, result_add};
            OP_SUB:  capture_val = {8'd0, result_sub};
            OP_MUL:  capture_val = result_mul;
            default: capture_val = {8'd0, result_div};
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= ST_ENTER_A;
            a_reg            <= 8'd0;
            b_reg            <= 8'd0;
            a_cnt_reg        <= '0;
            b_cnt_reg        <= '0;
            op_reg           <= OP_ADD;
            exec_cnt_reg     <= '0;
            result_reg       <= 16'd0;
            result_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            a_reg            <= a_next;
            b_reg            <= b_next;
            a_cnt_reg        <= a_cnt_next;
            b_cnt_reg        <= b_cnt_next;
            op_reg           <= op_next;
            exec_cnt_reg     <= exec_cnt_next;
            result_reg       <= result_next;
            result_valid_reg <= result_valid_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        a_next            = a_reg;
        b_next            = b_reg;
        a_cnt_next        = a_cnt_reg;
        b_cnt_next        = b_cnt_reg;
        op_next           = op_reg;
        exec_cnt_next     = exec_cnt_reg;
        result_next       = result_reg;
        result_valid_next = 1'b0;

        if (key_valid && (key_type == KEY_CLR)) begin
            // Clear beats everything, including an EXEC in progress; the
            // last displayed result is deliberately kept.
            state_next    = ST_ENTER_A;
            a_next        = 8'd0;
            b_next        = 8'd0;
            a_cnt_next    = '0;
            b_cnt_next    = '0;
            op_next       = OP_ADD;
            exec_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_ENTER_A: begin
                    if (key_valid) begin
                        case (key_type)
                            KEY_DIGIT: begin
                                // Digit limit is checked first: a 4th digit is
                                // dropped silently rather than overflowing.
                                if (digit_ok && digit_room) begin
                                    if (acc_wide > 12'd255) begin
                                        state_next = ST_ERR;
                                    end else begin
                                        a_next     = acc_wide[7:0];
                                        a_cnt_next = a_cnt_reg + CNT_ONE;
                                    end
                                end
                            end
                            KEY_OP: begin
                                if (op_ok && (a_cnt_reg != '0)) begin
                                    op_next    = key_val[1:0];
                                    state_next = ST_ENTER_B;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ST_ENTER_B: begin
                    if (key_valid) begin
                        case (key_type)
                            KEY_DIGIT: begin
                                if (digit_ok && digit_room) begin
                                    if (acc_wide > 12'd255) begin
                                        state_next = ST_ERR;
                                    end else begin
                                        b_next     = acc_wide[7:0];
                                        b_cnt_next = b_cnt_reg + CNT_ONE;
                                    end
                                end
                            end
                            KEY_OP: begin
                                // Operator may be changed until B entry starts.
                                if (op_ok && (b_cnt_reg == '0)) begin
                                    op_next = key_val[1:0];
                                end
                            end
                            KEY_EQ: begin
                                if (b_cnt_reg != '0) begin
                                    state_next    = ST_EXEC;
                                    exec_cnt_next = '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ST_EXEC: begin
                    if (exec_last) begin
                        if (alu_error) begin
                            state_next = ST_ERR;
                        end else begin
                            result_next       = capture_val;
                            result_valid_next = 1'b1;
                            state_next        = ST_DONE;
                        end
                    end else begin
                        exec_cnt_next = exec_cnt_reg + EXEC_ONE;
                    end
                end

                ST_DONE: begin
                    if (key_valid) begin
                        if ((key_type == KEY_DIGIT) && digit_ok) begin
                            // A fresh digit starts a brand-new calculation.
                            state_next = ST_ENTER_A;
                            a_next     = {4'd0, key_val};
                            a_cnt_next = CNT_ONE;
                            b_next     = 8'd0;
                            b_cnt_next = '0;
                        end
`ifdef CALC_CHAIN_EN
                        else if ((key_type == KEY_OP) && op_ok) begin
                            if (result_reg > 16'd255) begin
                                state_next = ST_ERR;
                            end else begin
                                a_next     = result_reg[7:0];
                                a_cnt_next = CNT_ONE;
                                b_next     = 8'd0;
                                b_cnt_next = '0;
                                op_next    = key_val[1:0];
                                state_next = ST_ENTER_B;
                            end
                        end
`endif
                    end
                end

                ST_ERR: ;   // only clear (handled above) leaves ERR

                default: state_next = ST_ENTER_A;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    logic [3:0] enable_vec;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_enable
            assign enable_vec[gi] = (state_reg == ST_EXEC) && (op_reg == 2'(gi));
        end
    endgenerate

    assign enable_add   = enable_vec[0];
    assign enable_sub   = enable_vec[1];
    assign enable_mul   = enable_vec[2];
    assign enable_div   = enable_vec[3];

    assign key_ready    = (state_reg != ST_EXEC);
    assign A            = a_reg;
    assign B            = b_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign error        = (state_reg == ST_ERR);
    assign state_dbg    = state_reg;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_operand_sequencer
//
// Drives keypad sequences into calc_operand_sequencer with a behavioural ALU
// attached. A table of single-key vectors checks state/operands/enables after
// every key; hand-written sequences cover errors, clear in EXEC, reset and
// chaining. Expected results are queued when '=' is pressed and compared
// when result_valid pulses.
// ---------------------------------------------------------------------------
module tb_calc_operand_sequencer;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [1:0]  key_type;
    logic [3:0]  key_val;
    logic        key_ready;
    logic [7:0]  A, B;
    logic        enable_add, enable_sub, enable_mul, enable_div;
    logic [8:0]  result_add;
    logic [7:0]  result_sub;
    logic [15:0] result_mul;
    logic [7:0]  result_div;
    logic        alu_error;
    logic [15:0] result;
    logic        result_valid;
    logic        error;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    localparam logic [1:0] KD = 2'b00, KO = 2'b01, KE = 2'b10, KC = 2'b11;

    calc_operand_sequencer #(.MAX_DIGITS(3), .EXEC_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_type(key_type),
        .key_val(key_val), .key_ready(key_ready), .A(A), .B(B),
        .enable_add(enable_add), .enable_sub(enable_sub),
        .enable_mul(enable_mul), .enable_div(enable_div),
        .result_add(result_add), .result_sub(result_sub),
        .result_mul(result_mul), .result_div(result_div),
        .alu_error(alu_error), .result(result), .result_valid(result_valid),
        .error(error), .state_dbg(state_dbg)
    );

    // Behavioural combinational ALU
    assign result_add = {1'b0, A} + {1'b0, B};
    assign result_sub = A - B;
    assign result_mul = {8'd0, A} * {8'd0, B};
    assign result_div = (B == 8'd0) ? 8'd0 : (A / B);
    assign alu_error  = (enable_sub && (A < B)) || (enable_div && (B == 8'd0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic press(input logic [1:0] kt, input logic [3:0] kv);
        key_valid = 1'b1;
        key_type  = kt;
        key_val   = kv;
        @(negedge clk);
        key_valid = 1'b0;
        key_type  = 2'b00;
        key_val   = 4'd0;
        $display("key type=%0d val=%0d -> state=%0d A=%0d B=%0d", kt, kv, state_dbg, A, B);
    endtask

    // Scoreboard: every result_valid pulse must match the oldest queued value.
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL result_valid unexpected pulse result=%0d", result);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("scoreboard_result", {16'd0, result}, {16'd0, e});
                $display("result_valid result=%0d exp=%0d", result, e);
            end
        end
    end

    typedef struct {
        logic        kv_en;
        logic [1:0]  kt;
        logic [3:0]  kv;
        logic [2:0]  st;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  en;    // {div, mul, sub, add}
        logic        push;
        logic [15:0] res;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic kv_en, input logic [1:0] kt, input logic [3:0] kv,
                                input logic [2:0] st, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] en, input logic push, input logic [15:0] res);
        vec_t v;
        v.kv_en = kv_en; v.kt = kt; v.kv = kv; v.st = st; v.a = a; v.b = b;
        v.en = en; v.push = push; v.res = res;
        return v;
    endfunction

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_type  = 2'b00;
        key_val   = 4'd0;

        // ---- vector table ----
        vecs.push_back(mk(1, KE, 0, 0,   0,   0, 4'b0000, 0, 0));     // '=' in ENTER_A ignored
        vecs.push_back(mk(1, KD, 1, 0,   1,   0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KD, 2, 0,  12,   0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KO, 0, 1,  12,   0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KE, 0, 1,  12,   0, 4'b0000, 0, 0));     // no B digit yet
        vecs.push_back(mk(1, KD, 3, 1,  12,   3, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KD, 4, 1,  12,  34, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KE, 0, 2,  12,  34, 4'b0001, 1, 46));
        vecs.push_back(mk(0, KD, 0, 3,  12,  34, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KD, 2, 0,   2,   0, 4'b0000, 0, 0));     // DONE + digit
        vecs.push_back(mk(1, KD, 5, 0,  25,   0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KD, 5, 0, 255,   0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KO, 2, 1, 255,   0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KD, 2, 1, 255,   2, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KD, 5, 1, 255,  25, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KD, 5, 1, 255, 255, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KD, 5, 1, 255, 255, 4'b0000, 0, 0));     // 4th digit dropped
        vecs.push_back(mk(1, KE, 0, 2, 255, 255, 4'b0100, 1, 16'hFE01));
        vecs.push_back(mk(0, KD, 0, 3, 255, 255, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KD, 4'hA, 3, 255, 255, 4'b0000, 0, 0));  // non-digit ignored
        vecs.push_back(mk(1, KC, 0, 0,   0,   0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KO, 1, 0,   0,   0, 4'b0000, 0, 0));     // op without A digit
        vecs.push_back(mk(1, KD, 4'hC, 0, 0,  0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KD, 1, 0,   1,   0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KD, 2, 0,  12,   0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KD, 3, 0, 123,   0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KD, 4, 0, 123,   0, 4'b0000, 0, 0));     // 1,2,3,4 -> 123
        vecs.push_back(mk(1, KO, 1, 1, 123,   0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KO, 3, 1, 123,   0, 4'b0000, 0, 0));     // op replaced
        vecs.push_back(mk(1, KD, 8, 1, 123,   8, 4'b0000, 0, 0));
        vecs.push_back(mk(1, KO, 0, 1, 123,   8, 4'b0000, 0, 0));     // op ignored now
        vecs.push_back(mk(1, KE, 0, 2, 123,   8, 4'b1000, 1, 15));
        vecs.push_back(mk(0, KD, 0, 3, 123,   8, 4'b0000, 0, 0));

        // ---- reset ----
        repeat (3) @(negedge clk);
        chk("reset_state", {29'd0, state_dbg}, 0);
        chk("reset_A", {24'd0, A}, 0);
        chk("reset_B", {24'd0, B}, 0);
        chk("reset_result", {16'd0, result}, 0);
        chk("reset_result_valid", {31'd0, result_valid}, 0);
        chk("reset_error", {31'd0, error}, 0);
        chk("reset_key_ready", {31'd0, key_ready}, 1);
        chk("reset_enables", {28'd0, enable_div, enable_mul, enable_sub, enable_add}, 0);
        rst_n = 1'b1;

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].push) exp_q.push_back(vecs[i].res);
            if (vecs[i].kv_en) press(vecs[i].kt, vecs[i].kv);
            else @(negedge clk);
            chk($sformatf("vec%0d_state", i), {29'd0, state_dbg}, {29'd0, vecs[i].st});
            chk($sformatf("vec%0d_A", i), {24'd0, A}, {24'd0, vecs[i].a});
            chk($sformatf("vec%0d_B", i), {24'd0, B}, {24'd0, vecs[i].b});
            chk($sformatf("vec%0d_en", i),
                {28'd0, enable_div, enable_mul, enable_sub, enable_add}, {28'd0, vecs[i].en});
            chk($sformatf("vec%0d_ready", i), {31'd0, key_ready}, {31'd0, (vecs[i].st != 3'd2)});
        end

        // ---- 20 - 50 with borrow -> ERR ----
        press(KC, 0);
        press(KD, 2); press(KD, 0); press(KO, 1); press(KD, 5); press(KD, 0);
        press(KE, 0);
        chk("sub_exec_enable", {31'd0, enable_sub}, 1);
        @(negedge clk);
        chk("sub_err_state", {29'd0, state_dbg}, 4);
        chk("sub_err_flag", {31'd0, error}, 1);
        chk("sub_err_no_valid", {31'd0, result_valid}, 0);
        press(KD, 3);
        chk("err_digit_ignored", {29'd0, state_dbg}, 4);
        press(KC, 0);
        chk("err_clear_state", {29'd0, state_dbg}, 0);
        chk("err_clear_flag", {31'd0, error}, 0);
        chk("clear_holds_result", {16'd0, result}, 15);

        // ---- 7 / 0 -> ERR; then 2,5,6 overflow ----
        press(KD, 7); press(KO, 3); press(KD, 0); press(KE, 0);
        @(negedge clk);
        chk("div0_err_state", {29'd0, state_dbg}, 4);
        press(KC, 0);
        press(KD, 2); press(KD, 5);
        press(KD, 6);
        chk("ovf_err_state", {29'd0, state_dbg}, 4);
        chk("ovf_A_unchanged", {24'd0, A}, 25);
        press(KC, 0);
        chk("ovf_clear_A", {24'd0, A}, 0);

        // ---- key dropped during EXEC, then clear aborting EXEC ----
        exp_q.push_back(16'd2);
        press(KD, 1); press(KO, 0); press(KD, 1); press(KE, 0);
        chk("exec_ready_low", {31'd0, key_ready}, 0);
        press(KD, 5);                                   // dropped: DUT in EXEC
        chk("exec_drop_state", {29'd0, state_dbg}, 3);
        chk("exec_drop_A", {24'd0, A}, 1);
        press(KD, 2); press(KO, 0); press(KD, 1); press(KE, 0);
        chk("abort_exec_enable", {31'd0, enable_add}, 1);
        press(KC, 0);
        chk("abort_state", {29'd0, state_dbg}, 0);
        chk("abort_enables", {28'd0, enable_div, enable_mul, enable_sub, enable_add}, 0);
        chk("abort_result_held", {16'd0, result}, 2);
        repeat (3) @(negedge clk);

        // ---- reset mid-entry, with a key presented during reset ----
        press(KD, 4); press(KD, 5); press(KO, 0); press(KD, 6);
        rst_n = 1'b0;
        press(KD, 7);
        rst_n = 1'b1;
        chk("midrst_state", {29'd0, state_dbg}, 0);
        chk("midrst_A", {24'd0, A}, 0);
        chk("midrst_B", {24'd0, B}, 0);
        chk("midrst_result", {16'd0, result}, 0);
        chk("midrst_error", {31'd0, error}, 0);
        chk("midrst_ready", {31'd0, key_ready}, 1);

        // ---- chaining from DONE ----
        exp_q.push_back(16'd10);
        press(KD, 9); press(KO, 0); press(KD, 1); press(KE, 0);
        @(negedge clk);
        press(KO, 1);
`ifdef CALC_CHAIN_EN
        chk("chain_state", {29'd0, state_dbg}, 1);
        chk("chain_A", {24'd0, A}, 10);
        exp_q.push_back(16'd6);
        press(KD, 4); press(KE, 0);
        @(negedge clk);
        chk("chain_done", {29'd0, state_dbg}, 3);
`else
        chk("nochain_state", {29'd0, state_dbg}, 3);
        chk("nochain_A", {24'd0, A}, 9);
        press(KE, 0);
        chk("nochain_eq_state", {29'd0, state_dbg}, 3);
`endif

        // ---- drain scoreboard with a bounded wait ----
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain pending=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
